// File: rtl/pipelined_divider_v2_if.sv
// Issue/result bus of the pipelined divider: reservation-station side (master)
// and divider side (slave).
interface pipelined_divider_v2_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 7,
  parameter int PC_W  = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  A;
  logic [XLEN-1:0]  B;
  logic [3:0]       divider_op_in;
  logic [TAG_W-1:0] Physical_address_in;
  logic [PC_W-1:0]  PC_in;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  Result;
  logic [TAG_W-1:0] Physical_address_out;
  logic [PC_W-1:0]  PC_out;

  modport master (
    output in_valid, A, B, divider_op_in, Physical_address_in, PC_in, flush, out_ready,
    input  in_ready, out_valid, Result, Physical_address_out, PC_out
  );

  modport slave (
    input  in_valid, A, B, divider_op_in, Physical_address_in, PC_in, flush, out_ready,
    output in_ready, out_valid, Result, Physical_address_out, PC_out
  );
endinterface

// File: rtl/pipelined_divider_v2.sv
// Fully pipelined restoring divider (RISC-V DIV/DIVU/REM/REMU), BITS_PER_STAGE quotient bits per stage.
// Optional macro DIV_OCCUPANCY_EN adds an in-flight op counter output.
module pipelined_divider_v2 #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_STAGE = 1,
  parameter int TAG_W          = 7,
  parameter int PC_W           = 32
) (
  input  logic clk,
  input  logic reset,
  pipelined_divider_v2_if.slave bus
`ifdef DIV_OCCUPANCY_EN
  ,
  output logic [$clog2(XLEN/BITS_PER_STAGE+3)-1:0] occupancy
`endif
);

  localparam int N = XLEN / BITS_PER_STAGE;
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef struct packed {
    logic             is_rem;
    logic             neg_q;
    logic             neg_r;
    logic             dz;
    logic             ovf;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  pc;
    logic [XLEN-1:0]  a_raw;
    logic [XLEN-1:0]  rem;
    logic [XLEN-1:0]  quo;
    logic [XLEN-1:0]  dvs;
  } stage_t;

  logic            advance;
  logic            accept;
  logic            drain;
  logic [N:0]      vld_d, vld_q;
  stage_t          st_d [0:N];
  stage_t          st_q [0:N];
  logic            out_valid_d, out_valid_q;
  logic [XLEN-1:0] result_d, result_q;
  logic [TAG_W-1:0] tag_d, tag_q;
  logic [PC_W-1:0] pc_d, pc_q;

  function automatic stage_t load_s0(input logic [3:0] op, input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag,
                                     input logic [PC_W-1:0] pc);
    stage_t s;
    logic   is_signed;
    logic   sa;
    logic   sb;
    is_signed = (op == 4'b0000) || (op == 4'b0010);
    sa        = is_signed && a[XLEN-1];
    sb        = is_signed && b[XLEN-1];
    s.is_rem  = !((op == 4'b0000) || (op == 4'b0001));
    s.neg_q   = sa ^ sb;
    s.neg_r   = sa;
    s.dz      = (b == '0);
    s.ovf     = is_signed && (a == MIN_VAL) && (b == '1);
    s.tag     = tag;
    s.pc      = pc;
    s.a_raw   = a;
    s.rem     = '0;
    s.quo     = sa ? -a : a;
    s.dvs     = sb ? -b : b;
    return s;
  endfunction

  // Dividend magnitude shifts out of quo MSB-first while quotient bits shift in at the LSB.
  function automatic stage_t iter_step(input stage_t s);
    stage_t          r;
    logic [XLEN:0]   trial;
    r = s;
    for (int i = 0; i < BITS_PER_STAGE; i++) begin
      trial = {r.rem, r.quo[XLEN-1]};
      r.quo = {r.quo[XLEN-2:0], 1'b0};
      if (trial >= {1'b0, r.dvs}) begin
        trial    = trial - {1'b0, r.dvs};
        r.quo[0] = 1'b1;
      end
      r.rem = trial[XLEN-1:0];
    end
    return r;
  endfunction

  function automatic logic [XLEN-1:0] finalize(input stage_t s);
    logic [XLEN-1:0] res;
    if (s.dz)          res = s.is_rem ? s.a_raw : '1;
    else if (s.ovf)    res = s.is_rem ? '0 : MIN_VAL;
    else if (s.is_rem) res = s.neg_r ? -s.rem : s.rem;
    else               res = s.neg_q ? -s.quo : s.quo;
    return res;
  endfunction

  assign advance      = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && advance && !bus.flush;
  assign drain        = out_valid_q && bus.out_ready;
  assign bus.in_ready = advance;

  always_comb begin
    vld_d       = vld_q;
    st_d        = st_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    tag_d       = tag_q;
    pc_d        = pc_q;
    if (advance) begin
      // S0: operand conditioning
      vld_d    = {vld_q[N-1:0], accept};
      st_d[0]  = load_s0(bus.divider_op_in, bus.A, bus.B, bus.Physical_address_in, bus.PC_in);
      // S1..SN: restoring iterations
      for (int k = 1; k <= N; k++) st_d[k] = iter_step(st_q[k-1]);
      // output register: sign fix-up and special cases
      out_valid_d = vld_q[N];
      result_d    = finalize(st_q[N]);
      tag_d       = st_q[N].tag;
      pc_d        = st_q[N].pc;
    end
    if (bus.flush) begin
      vld_d       = '0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    st_q <= st_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      tag_q       <= '0;
      pc_q        <= '0;
    end else begin
      vld_q       <= vld_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      tag_q       <= tag_d;
      pc_q        <= pc_d;
    end
  end

  assign bus.out_valid            = out_valid_q;
  assign bus.Result               = result_q;
  assign bus.Physical_address_out = tag_q;
  assign bus.PC_out               = pc_q;

`ifdef DIV_OCCUPANCY_EN
  localparam int OCC_W = $clog2(N + 3);
  logic [OCC_W-1:0] occ_d, occ_q;

  always_comb begin
    occ_d = occ_q;
    if (bus.flush)            occ_d = '0;
    else if (accept && !drain) occ_d = occ_q + OCC_W'(1);
    else if (!accept && drain) occ_d = occ_q - OCC_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) occ_q <= '0;
    else        occ_q <= occ_d;
  end

  assign occupancy = occ_q;
`endif

endmodule
